imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_array.sv | 29 ++
 rtl/imem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
package imem_pkg;

  // Width of the wait-state counter (WAIT_CYCLES spans 0..15).
  localparam int WAIT_W = 4;

  // RISC-V canonical NOP (addi x0, x0, 0), returned on a faulting fetch.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word offset of a byte address from the memory base, modulo 2^32.
  function automatic logic [29:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-organised instruction storage: synchronous byte-enable write,
// combinational read. Contents are deliberately not reset.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; a read on the same edge still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with programmable wait
// states, range/alignment checking and a side-band program-load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [31:0]       addr_q;

  // Fetch lookup path. With zero wait states the array is sampled on the
  // accept edge itself, so the live request address is used while in IDLE.
  logic [31:0] look_addr;
  logic [29:0] look_off;
  logic        look_err;
  logic [31:0] rd_data;

  assign look_addr = (state == IDLE) ? req_addr : addr_q;
  assign look_off  = word_off(look_addr, BASE_ADDR);
  assign look_err  = (look_addr[1:0] != 2'b00) || (look_off >= 30'(DEPTH));

  // Load path: faulting writes are simply not forwarded to the array.
  logic [29:0] wr_off;
  logic        wr_ok;

  assign wr_off = word_off(wr_addr, BASE_ADDR);
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (wr_off < 30'(DEPTH));

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_idx  (wr_off[AW-1:0]),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_idx  (look_off[AW-1:0]),
    .rd_data (rd_data)
  );

  // Fetch FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= look_err;
              rsp_data  <= look_err ? NOP : rd_data;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= look_err;
            rsp_data  <= look_err ? NOP : rd_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
